// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: write-side bus between producers, the arbiter and the FIFO memory.
//   req       per-requester write request (held until granted)
//   req_data  packed request data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   gnt       one-hot grant, high in the cycle a word is accepted
//   wfull     FIFO full flag from the write-pointer logic
//   wdata     registered write data to the memory
//   wclken    registered write enable to the memory
// Modport master is the arbiter side; slave is the producer/memory environment.
interface fifo_wr_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            gnt;
    logic                          wfull;
    logic [DATA_WIDTH-1:0]         wdata;
    logic                          wclken;

    modport master (
        input  req, req_data, wfull,
        output gnt, wdata, wclken
    );

    modport slave (
        output req, req_data, wfull,
        input  gnt, wdata, wclken
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing the FIFO write port among NUM_REQ requesters.
// Grants bounded bursts (up to MAX_BURST words) per owner, then rotates. The output register
// is a one-entry pipeline stage (valid = wclken) that holds while wfull is high.
// Ports:
//   wclk       write-domain clock
//   wrst       asynchronous active-high reset
//   bus        fifo_wr_arbiter_if.master (req, req_data, wfull in; gnt, wdata, wclken out)
//   stall_cnt  saturating count of cycles with a request blocked by a full FIFO
//              (only present when FIFO_WR_ARB_STALL_CNT_EN is defined)
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                   wclk,
    input  logic                   wrst,
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    fifo_wr_arbiter_if.master      bus,
    output logic [15:0]            stall_cnt
`else
    fifo_wr_arbiter_if.master      bus
`endif
);
    localparam int unsigned IdxW = $clog2(NUM_REQ);

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e                state_q, state_d;
    logic [IdxW-1:0]       owner_q, owner_d;
    logic [IdxW-1:0]       last_ptr_q, last_ptr_d;
    logic [7:0]            burst_cnt_q, burst_cnt_d;
    logic [7:0]            cnt_inc;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  wclken_q, wclken_d;

    logic [IdxW-1:0]       sel;
    logic                  sel_valid;
    logic                  can_accept;
    logic                  accept;
    logic [NUM_REQ-1:0]    gnt;

    // Output stage is free unless it holds a word the full FIFO has not taken yet.
    assign can_accept = !wclken_q || !bus.wfull;

    // Candidate selection: in IDLE, first requester after last_ptr (wrapping); in BURST, owner.
    // The IDLE scan runs from the farthest offset down so the nearest hit wins.
    always_comb begin
        sel       = owner_q;
        sel_valid = 1'b0;
        if (state_q == StIdle) begin
            for (int k = int'(NUM_REQ); k >= 1; k--) begin
                if (bus.req[(int'(last_ptr_q) + k) % int'(NUM_REQ)]) begin
                    sel       = IdxW'((int'(last_ptr_q) + k) % int'(NUM_REQ));
                    sel_valid = 1'b1;
                end
            end
        end else begin
            sel_valid = bus.req[owner_q];
        end
    end

    // Gated by wrst so no grant is seen while the requester's word would be discarded.
    assign accept = can_accept && sel_valid && !wrst;

    always_comb begin
        gnt = '0;
        if (accept) begin
            gnt[sel] = 1'b1;
        end
    end

    assign bus.gnt    = gnt;
    assign bus.wdata  = wdata_q;
    assign bus.wclken = wclken_q;

    assign cnt_inc = burst_cnt_q + 8'd1;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_ptr_d  = last_ptr_q;
        burst_cnt_d = burst_cnt_q;
        wdata_d     = wdata_q;
        wclken_d    = wclken_q;

        if (can_accept) begin
            wclken_d = accept;
            if (accept) begin
                wdata_d = bus.req_data[int'(sel)*int'(DATA_WIDTH) +: DATA_WIDTH];
            end
        end

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    owner_d     = sel;
                    last_ptr_d  = sel;
                    burst_cnt_d = 8'd1;
                    state_d     = (MAX_BURST > 1) ? StBurst : StIdle;
                end
            end
            StBurst: begin
                if (accept) begin
                    burst_cnt_d = cnt_inc;
                    if (cnt_inc == 8'(MAX_BURST)) begin
                        state_d = StIdle;
                    end
                end else if (can_accept) begin
                    // Owner withdrew: release with a one-cycle bubble.
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state_q     <= StIdle;
            owner_q     <= '0;
            last_ptr_q  <= IdxW'(NUM_REQ - 1);
            burst_cnt_q <= '0;
            wdata_q     <= '0;
            wclken_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_ptr_q  <= last_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            wdata_q     <= wdata_d;
            wclken_q    <= wclken_d;
        end
    end

`ifdef FIFO_WR_ARB_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            stall_cnt_q <= '0;
        end else if ((|bus.req) && !can_accept && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the FIFO memory among NUM_REQ requesters in the write-clock domain.
- Selects one requester, runs bounded write bursts for it and drives the write-data and write-enable into the memory.
- Holds any pending write while wfull is high, so no accepted word is ever dropped.
- Sits between the producer blocks and the FIFO memory/write-pointer logic; wclken feeds both.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 8, write data width; matches the FIFO memory data width.
- MAX_BURST, 4, maximum consecutive accepted words per grant before rotation (1..255).

Ports:
- wclk  input  1  write-domain clock.
- wrst  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  per-requester write request; requester must hold req and data until gnt.
- req_data  input  NUM_REQ*DATA_WIDTH  packed data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- gnt  output  NUM_REQ  one-hot; gnt[i]=1 in the cycle requester i's word is accepted.
- wfull  input  1  FIFO full flag from the write-pointer logic.
- wdata  output  DATA_WIDTH  registered write data to the memory.
- wclken  output  1  registered write enable to the memory; memory writes on posedge wclk when wclken && !wfull.

Behaviour:
- Reset (async, while wrst=1): wdata=0, wclken=0, gnt=0, state=IDLE, burst_cnt=0, last_ptr=NUM_REQ-1 (requester 0 has first priority).
- Output register acts as a one-entry pipeline stage with valid=wclken.
  - can_accept = !wclken || !wfull, combinational.
  - If wclken && wfull: wdata and wclken hold unchanged; no acceptance occurs.
- Accept: in a cycle where can_accept=1 and the selected requester s has req[s]=1:
  - gnt[s]=1, combinational in that cycle.
  - Next edge: wdata<=req_data[s], wclken<=1.
- If can_accept=1 and no word is accepted, next edge: wclken<=0; wdata holds its last value.
- Latency: word accepted in cycle N is presented on wdata/wclken in cycle N+1. Throughput is 1 word/cycle while !wfull.
- FSM, two states:
  - IDLE:
    - s = first i with req[i]=1, searching from last_ptr+1 upward with modulo-NUM_REQ wrap.
    - On accept: owner<=s, burst_cnt<=1, last_ptr<=s.
    - If MAX_BURST>1, go to BURST; else stay in IDLE.
    - No request, or can_accept=0: stay in IDLE; no pointer change.
  - BURST:
    - s = owner; only the owner can be granted.
    - On accept: burst_cnt<=burst_cnt+1; when the new count equals MAX_BURST, go to IDLE.
    - If req[owner]=0 in a cycle where can_accept=1: go to IDLE with no grant that cycle. The one-cycle bubble is intentional.
    - can_accept=0: hold state, owner and burst_cnt.
- Rotation: because last_ptr=owner, the next IDLE search starts after the owner. Every requester is served within NUM_REQ bursts.
- Simultaneous wfull rise with a pending write: the word stays in the output register until wfull falls, then is written. It is never duplicated (the memory gates on wfull).
- wrst asserted mid-burst: everything returns to reset values immediately, and any pending output word is discarded. The requester sees no gnt and must keep req high.
- gnt is never asserted for a requester with req=0. At most one gnt bit is high per cycle.

Optional Feature:
- Macro: FIFO_WR_ARB_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt [15:0].
  - Increments by 1 every wclk in which (|req)=1 and can_accept=0; saturates at 16'hFFFF.
  - Cleared to 0 by wrst.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset release, req=4'b0001, req_data[7:0]=8'hA5, wfull=0 -> gnt=4'b0001 in the first cycle; next cycle wdata=8'hA5, wclken=1; wclken=0 the cycle after if req drops.
- req=4'b1111 held, MAX_BURST=4, wfull=0 -> grants 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0…; wclken stays 1 every cycle; exactly 16 words in 16 cycles.
- Burst to requester 2, req[2] drops after 2 words while req[3]=1 -> one idle cycle with gnt=0, then gnt=4'b1000.
- Pending word 8'h3C with wclken=1 and wfull held high for 5 cycles -> wdata=8'h3C and wclken=1 stable, gnt=0 throughout; wfull falls -> exactly one write of 8'h3C, then the next grant proceeds.
- wrst pulsed in the third cycle of a burst from requester 1 -> wclken=0, gnt=0 immediately; after release with req=4'b0011, first grant goes to requester 0.
- With FIFO_WR_ARB_STALL_CNT_EN: req=4'b0001, pending word held, wfull high for 7 cycles -> stall_cnt=7. A 70000-cycle stall -> stall_cnt=16'hFFFF.
